// File: rtl/mips_pipe_pkg.sv
// Shared widths, reset control value and the pipe-entry record used by the
// pipeline stage registers.
package mips_pipe_pkg;

  localparam int unsigned CTRL_W_DEF = 3;
  localparam int unsigned DATA_W_DEF = 69;
  localparam logic [CTRL_W_DEF-1:0] CTRL_RST_DEF = '0;

  typedef struct packed {
    logic                  valid;
    logic [CTRL_W_DEF-1:0] ctrl;
    logic [DATA_W_DEF-1:0] data;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One valid/ctrl/data slot of a pipeline stage with load, clear and async reset.
module pipe_entry_reg
  import mips_pipe_pkg::*;
#(
  parameter int unsigned           CTRL_W   = CTRL_W_DEF,
  parameter int unsigned           DATA_W   = DATA_W_DEF,
  parameter logic [CTRL_W-1:0]     CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Clear only drops the valid bit; payload is left as-is to save enables.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = d_ctrl;
      data_d  = d_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_RST;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign q_valid = valid_q;
  assign q_ctrl  = ctrl_q;
  assign q_data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline stage register with stall, flush and
// valid/ready handshaking on both sides.
module pipe_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int unsigned       CTRL_W   = CTRL_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(CTRL_RST_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              le,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  logic              push, pop;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic [CTRL_W-1:0] main_ctrl_in;
  logic [DATA_W-1:0] main_data_in;

  // Gated by reset so nothing is offered acceptance while held in reset.
  assign in_ready  = reset & ~skid_valid & ~le & ~flush;
  assign out_valid = main_valid & ~le;
  assign out_ctrl  = out_valid ? main_ctrl : CTRL_RST;
  assign out_data  = main_data;
  assign count     = {1'b0, main_valid} + {1'b0, skid_valid};

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Skid is only ever filled behind a valid main, so main is never empty
  // while skid holds an entry; a pop with skid valid cannot coincide with push.
  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (pop) begin
      if (skid_valid) begin
        main_load      = 1'b1;
        main_from_skid = 1'b1;
        skid_clear     = 1'b1;
      end else if (push) begin
        main_load = 1'b1;
      end else begin
        main_clear = 1'b1;
      end
    end else if (push) begin
      if (main_valid) skid_load = 1'b1;
      else            main_load = 1'b1;
    end
  end

  always_comb begin
    main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
    main_data_in = main_from_skid ? skid_data : in_data;
  end

  pipe_entry_reg #(
    .CTRL_W  (CTRL_W),
    .DATA_W  (DATA_W),
    .CTRL_RST(CTRL_RST)
  ) u_main (
    .clk    (clk),
    .rst_n  (reset),
    .load   (main_load),
    .clear  (main_clear),
    .d_ctrl (main_ctrl_in),
    .d_data (main_data_in),
    .q_valid(main_valid),
    .q_ctrl (main_ctrl),
    .q_data (main_data)
  );

  pipe_entry_reg #(
    .CTRL_W  (CTRL_W),
    .DATA_W  (DATA_W),
    .CTRL_RST(CTRL_RST)
  ) u_skid (
    .clk    (clk),
    .rst_n  (reset),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_ctrl (in_ctrl),
    .d_data (in_data),
    .q_valid(skid_valid),
    .q_ctrl (skid_ctrl),
    .q_data (skid_data)
  );

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 3: control-bit width, e.g. RegWrite/MemtoReg/MemWrite.
REQ-002 Parameter DATA_W, default 69: payload width, e.g. ALUResult 32 + WriteReg 5 + WriteData 32.
REQ-003 Parameter CTRL_RST, default all-zero: value driven on out_ctrl when the stage holds no valid entry.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: the block SHALL use one clock, and reset is asynchronous and active-low.
REQ-006 Port le, input, 1: hazard stall, active high; holds the stage frozen.
REQ-007 Port flush, input, 1: synchronous squash, active high; converts all entries to bubbles.
REQ-008 Port in_valid, input, 1: upstream offers an entry.
REQ-009 Port in_ready, output, 1: stage accepts an entry this cycle.
REQ-010 Port in_ctrl, input, CTRL_W: control bits of the offered entry.
REQ-011 Port in_data, input, DATA_W: payload of the offered entry.
REQ-012 Port out_valid, output, 1: stage presents a valid entry.
REQ-013 Port out_ready, input, 1: downstream accepts the entry.
REQ-014 Port out_ctrl, output, CTRL_W: control bits of the head entry, gated by validity.
REQ-015 Port out_data, output, DATA_W: payload of the head entry.
REQ-016 Port count, output, 2: occupancy, 0..2.

Function
REQ-017 Storage SHALL be two entries: main (head) and skid, each holding a valid bit, ctrl and data, in FIFO order.
REQ-018 Push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at the same edge.
REQ-019 in_ready SHALL equal !skid_valid & !le & !flush, with skid_valid a register output so the timing path is registered.
REQ-020 out_valid SHALL equal main_valid & !le.
REQ-021 out_ctrl SHALL equal main_ctrl when out_valid=1, else CTRL_RST.
REQ-022 out_data SHALL always reflect main_data, valid or not.
REQ-023 Empty stage + push: entry goes to main; out_valid=1 the next cycle, giving 1-cycle latency.
REQ-024 Main full, no pop, push: entry goes to skid; in_ready=0 from the next cycle.
REQ-025 Main full, pop, push, skid empty: the new entry replaces main; count is unchanged.
REQ-026 Both full, pop: skid moves to main and skid is cleared; in_ready=1 the next cycle.
REQ-027 Pop with no push and skid empty: main is invalidated.
REQ-028 le=1: no push, no pop, and all entries held unchanged regardless of in_valid/out_ready.
REQ-029 flush=1: both valid bits are cleared at the next edge, with priority over le, push and pop; data registers are not required to clear.
REQ-030 count SHALL equal main_valid + skid_valid.
REQ-031 Valid bits SHALL never reach a state with skid valid and main invalid.

Reset
REQ-032 reset low SHALL asynchronously clear both valid bits, set both ctrl fields to CTRL_RST and both data fields to 0.
REQ-033 During reset: out_valid=0, out_ctrl=CTRL_RST, out_data=0, count=0 and in_ready=0.
REQ-034 Reset asserted mid-transfer SHALL discard both entries; the first push after deassertion is the first entry emitted.

Structure
REQ-035 Package mips_pipe_pkg SHALL hold the default CTRL_W/DATA_W constants, CTRL_RST and a pipe-entry typedef (valid, ctrl, data).
REQ-036 One sub-module, pipe_entry_reg, SHALL implement a single valid/ctrl/data register with load, clear and async reset; it is instantiated twice.

Verification
REQ-037 Reset released, in_valid=1, in_data=0x1, out_ready=1 -> out_valid=1 and out_data=0x1 one cycle later; count=1.
REQ-038 out_ready=0, push 0xA then 0xB -> count=2, in_ready=0; then out_ready=1 -> 0xA, then 0xB emitted on consecutive cycles, in_ready=1 after the first pop.
REQ-039 Stage full, le=1 for 3 cycles with out_ready=1 and in_valid=1 -> out_valid=0, out_ctrl=0, count holds at 2, no entry lost or duplicated after le drops.
REQ-040 Stage full, ctrl=3'b101, flush and le both asserted for 1 cycle -> next cycle count=0, out_ctrl=3'b000, out_valid=0.
REQ-041 Continuous in_valid=1/out_ready=1 streaming 0..15 -> 16 entries emitted in order, one per cycle, count stays 1.
REQ-042 reset pulsed low asynchronously mid-cycle with count=2 -> outputs cleared immediately (before the next clk edge); next pushed value 0x55 is the first emitted.
